// File: rtl/fp8_decoder_pkg.sv
// Shared widths and FSM state encoding for the FP8 -> 13-bit decoder.
package fp8_decoder_pkg;
  localparam int FP8_W = 8;
  localparam int EXP_W = 3;
  localparam int SIG_W = 5;
  localparam int OUT_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SIGN  = 2'd2
  } state_t;
endpackage

// File: rtl/fp8_decoder_fifo.sv
// Synchronous FIFO for queued {S,E,F} codes; pointers carry one wrap bit.
module fp8_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/fp8_decoder.sv
// Iterative FP8 (S, E, F) to 13-bit two's-complement expander with a held,
// handshaked output register.
//   state    | meaning
//   ST_IDLE  | pop a queued code when available
//   ST_SHIFT | mag <<= 1 once per cycle, E cycles total
//   ST_SIGN  | apply sign and load D once the output slot is free
module fp8_decoder
  import fp8_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [SIG_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D,
  output logic             busy,
  output logic [15:0]      conv_count
);
  localparam logic [OUT_W-1:0] MAG_ONE = 1;
  localparam logic [EXP_W-1:0] CNT_ONE = 1;

  state_t             state_q;
  logic [OUT_W-1:0]   mag_q, d_q, res_d;
  logic [EXP_W-1:0]   cnt_q;
  logic               sgn_q, out_valid_q, slot_free;
  logic [15:0]        conv_count_q;
  logic [FP8_W:0]     head;
  logic               fifo_full, fifo_empty, fifo_pop;

  fp8_fifo #(.DEPTH(DEPTH), .W(FP8_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  ({S, E, F}),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign slot_free  = !out_valid_q || out_ready;
  // Negative zero falls out naturally: ~0 + 1 wraps to 0.
  assign res_d      = sgn_q ? (~mag_q + MAG_ONE) : mag_q;
  assign out_valid  = out_valid_q;
  assign D          = d_q;
  assign busy       = (state_q != ST_IDLE);
  assign conv_count = conv_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mag_q        <= '0;
      cnt_q        <= '0;
      sgn_q        <= 1'b0;
      d_q          <= '0;
      out_valid_q  <= 1'b0;
      conv_count_q <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q  <= 1'b0;
        conv_count_q <= conv_count_q + 16'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            sgn_q   <= head[FP8_W];
            cnt_q   <= head[FP8_W-1:SIG_W];
            mag_q   <= {{(OUT_W-SIG_W){1'b0}}, head[SIG_W-1:0]};
            state_q <= (head[FP8_W-1:SIG_W] != '0) ? ST_SHIFT : ST_SIGN;
          end
        end
        ST_SHIFT: begin
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= ST_SIGN;
        end
        ST_SIGN: begin
          if (slot_free) begin
            d_q         <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
